// File: rtl/ram_ctrl.sv
// Single-port synchronous RAM controller with a busy/valid read handshake,
// byte-lane writes, configurable read latency and out-of-range detection.
module ram_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int BUS_AW = 16,
  parameter int RD_LAT = 1
) (
  input  logic                clk_2,
  input  logic                rst_n,
  input  logic                mem_e,
  input  logic                mem_w,
  input  logic [BUS_AW-1:0]   mem_address,
  input  logic [DATA_W-1:0]   mem_in,
  input  logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_out,
  output logic                mem_valid,
  output logic                mem_busy,
  output logic                mem_err
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_addr_oor;
  logic [DATA_W-1:0] r_out;
  logic              r_valid;
  logic              r_busy;
  logic              r_err;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  logic              w_oor;
  logic              w_accept;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_idx;

  if (BUS_AW > ADDR_W) begin : g_oor
    assign w_oor = |mem_address[BUS_AW-1:ADDR_W];
  end else begin : g_no_oor
    assign w_oor = 1'b0;
  end

  assign w_idx    = mem_address[ADDR_W-1:0];
  assign w_accept = ~r_busy & (mem_e | mem_w);
  // rst_n gates the write so no array update can slip in while reset is held
  assign w_wr_en  = rst_n & w_accept & mem_w & ~w_oor;

  // Byte-lane array write; the array is deliberately left out of reset.
  always_ff @(posedge clk_2) begin
    if (w_wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= mem_in[8*i +: 8];
        end
      end
    end
  end

  // Request FSM: accepts requests in IDLE, counts out the read latency in RD.
  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_addr_oor <= 1'b0;
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && mem_w) begin
            r_err <= w_oor;
          end else if (w_accept) begin
            r_addr     <= w_idx;
            r_addr_oor <= w_oor;
            r_cnt      <= CNT_INIT;
            r_busy     <= 1'b1;
            r_state    <= ST_RD;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_RD: begin
          if (r_cnt == '0) begin
            r_out   <= r_addr_oor ? '0 : r_mem[r_addr];
            r_valid <= 1'b1;
            r_err   <= r_addr_oor;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_out   = r_out;
  assign mem_valid = r_valid;
  assign mem_busy  = r_busy;
  assign mem_err   = r_err;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: three instances (RD_LAT 1..3) share one stimulus stream;
// expected read results are queued per instance and checked on mem_valid.
module tb_ram_ctrl;

  localparam int NI = 3;

  logic        clk;
  logic        rst_n;
  logic        mem_e;
  logic        mem_w;
  logic [15:0] mem_address;
  logic [15:0] mem_in;
  logic [1:0]  mem_be;

  logic [15:0] out_a   [NI];
  logic        valid_a [NI];
  logic        busy_a  [NI];
  logic        err_a   [NI];

  int total;
  int bad;
  int werr [NI];
  int bcnt [NI];

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] q2[$];
  logic [15:0] mdl [8192];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ram_ctrl #(
      .DATA_W(16),
      .ADDR_W(13),
      .BUS_AW(16),
      .RD_LAT(g + 1)
    ) u_dut (
      .clk_2      (clk),
      .rst_n      (rst_n),
      .mem_e      (mem_e),
      .mem_w      (mem_w),
      .mem_address(mem_address),
      .mem_in     (mem_in),
      .mem_be     (mem_be),
      .mem_out    (out_a[g]),
      .mem_valid  (valid_a[g]),
      .mem_busy   (busy_a[g]),
      .mem_err    (err_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string tg(input string s, input int g);
    return $sformatf("%s_lat%0d", s, g + 1);
  endfunction

  task automatic push_exp(input int g, input logic [16:0] v);
    case (g)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int g, output logic [16:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    case (g)
      0: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int qsize(input int g);
    case (g)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Monitor: busy length, read completions against the scoreboard, write errors.
  always @(negedge clk) begin : mon
    logic [16:0] e;
    bit          ok;
    for (int g = 0; g < NI; g++) begin
      if (!rst_n) begin
        bcnt[g] = 0;
      end else begin
        if (busy_a[g]) begin
          bcnt[g]++;
        end else if (bcnt[g] != 0) begin
          chk(tg("busy_len", g), bcnt[g], g + 1);
          bcnt[g] = 0;
        end
        if (valid_a[g]) begin
          pop_exp(g, e, ok);
          if (!ok) begin
            chk(tg("unexp_valid", g), valid_a[g], 1'b0);
          end else begin
            chk(tg("rd_data", g), out_a[g], e[15:0]);
            chk(tg("rd_err", g), err_a[g], e[16]);
          end
        end else if (err_a[g]) begin
          chk(tg("wr_err_expected", g), (werr[g] > 0), 1'b1);
          if (werr[g] > 0) werr[g]--;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_a[0] | busy_a[1] | busy_a[2]) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("idle_timeout", busy_a[0] | busy_a[1] | busy_a[2], 1'b0);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] be, input logic rd_too);
    mem_address = a;
    mem_in      = d;
    mem_be      = be;
    mem_w       = 1'b1;
    mem_e       = rd_too;
    if (a[15:13] != 3'b000) begin
      for (int g = 0; g < NI; g++) werr[g]++;
    end else begin
      if (be[0]) mdl[a[12:0]][7:0]  = d[7:0];
      if (be[1]) mdl[a[12:0]][15:8] = d[15:8];
    end
    step();
    mem_w = 1'b0;
    mem_e = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a);
    mem_address = a;
    mem_e       = 1'b1;
    for (int g = 0; g < NI; g++) begin
      if (a[15:13] != 3'b000) push_exp(g, {1'b1, 16'h0000});
      else push_exp(g, {1'b0, mdl[a[12:0]]});
    end
    step();
    mem_e = 1'b0;
    wait_idle();
  endtask

  initial begin
    logic [15:0] ra;
    total = 0;
    bad   = 0;
    for (int g = 0; g < NI; g++) begin
      werr[g] = 0;
      bcnt[g] = 0;
    end
    rst_n       = 1'b0;
    mem_e       = 1'b0;
    mem_w       = 1'b0;
    mem_address = 16'h0000;
    mem_in      = 16'h0000;
    mem_be      = 2'b00;
    #3;
    for (int g = 0; g < NI; g++) begin
      chk(tg("rst_out", g), out_a[g], 16'h0000);
      chk(tg("rst_valid", g), valid_a[g], 1'b0);
      chk(tg("rst_busy", g), busy_a[g], 1'b0);
      chk(tg("rst_err", g), err_a[g], 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      step();
      for (int g = 0; g < NI; g++) chk(tg("idle_busy", g), busy_a[g], 1'b0);
    end

    do_write(16'h0042, 16'hBEEF, 2'b11, 1'b0);
    do_read(16'h0042);

    do_write(16'h0100, 16'h1234, 2'b11, 1'b0);
    do_write(16'h0100, 16'hAB00, 2'b10, 1'b0);
    do_read(16'h0100);

    do_write(16'h1FFF, 16'h0F0F, 2'b11, 1'b0);
    do_read(16'h2000);
    do_write(16'hFFFF, 16'h7777, 2'b11, 1'b0);
    do_read(16'h1FFF);

    do_write(16'h0042, 16'hC0DE, 2'b11, 1'b1);
    step();
    step();
    do_read(16'h0042);

    // Held read with a write pulse while busy: the write must not land.
    do_write(16'h0010, 16'h5AA5, 2'b11, 1'b0);
    mem_address = 16'h0010;
    mem_e       = 1'b1;
    for (int g = 0; g < NI; g++) begin
      for (int k = 0; k * (g + 2) < 4; k++) push_exp(g, {1'b0, mdl[13'h0010]});
    end
    step();
    mem_w  = 1'b1;
    mem_in = 16'hDEAD;
    mem_be = 2'b11;
    step();
    mem_w = 1'b0;
    step();
    step();
    mem_e = 1'b0;
    wait_idle();
    do_read(16'h0010);

    // Reset pulse in the middle of a read aborts it.
    do_write(16'h0050, 16'h5A5A, 2'b11, 1'b0);
    mem_address = 16'h0050;
    mem_e       = 1'b1;
    step();
    mem_e = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      chk(tg("abort_busy", g), busy_a[g], 1'b0);
      chk(tg("abort_out", g), out_a[g], 16'h0000);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();
    for (int g = 0; g < NI; g++) begin
      chk(tg("post_rst_busy", g), busy_a[g], 1'b0);
      chk(tg("post_rst_out", g), out_a[g], 16'h0000);
    end
    do_read(16'h0050);
    do_read(16'h0100);

    for (int i = 0; i < 8; i++) do_write(16'h0300 + 16'(i), 16'($urandom), 2'b11, 1'b0);
    for (int i = 0; i < 24; i++) begin
      ra = 16'h0300 + 16'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) do_write(ra, 16'($urandom), 2'($urandom), 1'b0);
      else do_read(ra);
    end

    repeat (4) step();
    for (int g = 0; g < NI; g++) begin
      chk(tg("queue_drained", g), qsize(g), 0);
      chk(tg("wr_err_seen", g), werr[g], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Parametrised single-port synchronous RAM controller, the next-generation replacement for the fixed 16-bit / 8K-word memory wrapper on the processor's data path. Requests are level-sampled on `clk_2` with an explicit busy/valid handshake instead of edge-triggered latching. The block adds configurable width, depth and read latency, byte-lane writes and out-of-range detection. It contains its own inferred memory array and sits between the processor's memory-access stage and nothing else.

## Interface
- `DATA_W`, 16: data width in bits; a multiple of 8.
- `ADDR_W`, 13: array address width; depth = 2^ADDR_W words.
- `BUS_AW`, 16: processor address bus width; must be at least `ADDR_W`.
- `RD_LAT`, 1: array read latency in cycles; legal range 1..3.
- `clk_2`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_e`  in  1  read request, level-sampled.
- `mem_w`  in  1  write request, level-sampled.
- `mem_address`  in  BUS_AW  word address.
- `mem_in`  in  DATA_W  write data.
- `mem_be`  in  DATA_W/8  byte enables for writes; bit i covers `mem_in[8i+7:8i]`.
- `mem_out`  out  DATA_W  read data; holds its value until the next read completes.
- `mem_valid`  out  1  one-cycle pulse: `mem_out` was updated.
- `mem_busy`  out  1  high while a read is in flight; requests are ignored while high.
- `mem_err`  out  1  one-cycle pulse: the completed access was out of range.

## Operation
- Out of range: `mem_address[BUS_AW-1:ADDR_W]` is nonzero. In range: the array index is `mem_address[ADDR_W-1:0]`.
- A request is accepted on a rising edge where `rst_n`=1, `mem_busy`=0 and (`mem_e` | `mem_w`).
- If `mem_e` and `mem_w` are both high, the write wins and the read is dropped. No error is flagged for the dropped read.
- Write: array bytes with `mem_be`=1 are updated at the accept edge; other bytes are unchanged. `mem_busy` stays 0 and there is no `mem_valid`. If the address is out of range, the array is not written and `mem_err` pulses in the cycle after the accept edge.
- Read: address captured at the accept edge. The returned data equals the array contents after that edge, including all earlier writes. If the address is out of range, `mem_out` is loaded with 0 and `mem_err` pulses together with `mem_valid`.
- FSM states:
  - IDLE: `mem_busy`=0. An accepted read loads the down-counter `cnt` with RD_LAT-1 and moves to RD.
  - RD: `mem_busy`=1. When `cnt`=0, load `mem_out`, pulse `mem_valid` (and `mem_err` if applicable), and return to IDLE. Otherwise decrement `cnt`.
- The counter width is the clog2 of `RD_LAT` (minimum 1 bit). With RD_LAT=1, RD lasts exactly one cycle.
- The array is not cleared by reset. Its contents are undefined at power-up.

## Timing
- Reset values: `mem_out`=0, `mem_valid`=0, `mem_busy`=0, `mem_err`=0, FSM=IDLE, `cnt`=0.
- Reset asserted mid-read aborts the read: no `mem_valid` and no `mem_out` update. Outputs take their reset values immediately, asynchronously.
- Read accepted at edge N:
  - `mem_busy`=1 from edge N to edge N+RD_LAT.
  - `mem_out`, `mem_valid`=1 and `mem_busy`=0 all change after edge N+RD_LAT.
  - The earliest next accept is edge N+RD_LAT+1.
  - Read throughput is one read per RD_LAT+1 cycles.
- Write accepted at edge N: the next request can be accepted at edge N+1. A read at N+1 of the same address returns the new data.
- Requests presented while `mem_busy`=1 are dropped, not queued. The requester must hold or retry.
- `mem_valid` and `mem_err` are never high for more than one cycle per access.

## Test plan
- Reset then idle, DATA_W=16, ADDR_W=13, RD_LAT=1 -> all outputs 0, `mem_busy` never asserts with no requests.
- Write 0xBEEF to 0x0042 (`mem_be`=2'b11), then read 0x0042 at the next edge -> `mem_busy` high 1 cycle, `mem_valid` pulse, `mem_out`=0xBEEF.
- Write 0x1234 (be=11), then 0xAB00 with be=2'b10 to 0x0100, then read 0x0100 -> `mem_out`=0xAB34.
- Read 0x2000 (out of range) with RD_LAT=3 -> busy for 3 cycles, then `mem_out`=0 with `mem_valid`=`mem_err`=1; a write to 0xFFFF -> `mem_err` pulses and the array is unchanged.
- RD_LAT=2, read 0x0010 holding `mem_e` high, plus a write pulse during busy -> the write is ignored, the second read is accepted at edge N+3, and both reads return the same data.
- `rst_n` low 1 cycle during RD, then high -> no `mem_valid`, `mem_busy`=0, `mem_out`=0, and earlier written data is still readable.
